// File: rtl/id_ex_hazard_stage_if.sv
// ID-to-EX bundle: decoded ID operands/control in, registered EX view plus
// hazard enables and stall statistics out.
interface id_ex_hazard_stage_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_uses_rt;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_mem_to_reg;
  logic             id_alu_src;
  logic [3:0]       id_alu_op;
  logic [31:0]      id_rdata1;
  logic [31:0]      id_rdata2;
  logic [31:0]      id_imm;
  logic             flush;

  logic             pc_write;
  logic             if_id_write;
  logic             ex_valid;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_mem_to_reg;
  logic             ex_alu_src;
  logic [3:0]       ex_alu_op;
  logic [31:0]      ex_rdata1;
  logic [31:0]      ex_rdata2;
  logic [31:0]      ex_imm;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op, id_rdata1,
           id_rdata2, id_imm, flush,
    input  pc_write, if_id_write, ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
           ex_rdata1, ex_rdata2, ex_imm, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op, id_rdata1,
           id_rdata2, id_imm, flush,
    output pc_write, if_id_write, ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
           ex_rdata1, ex_rdata2, ex_imm, stall_count
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection: inserts STALL_CYCLES
// bubbles while freezing PC and IF/ID; a branch flush squashes the ID slot.
module id_ex_hazard_stage #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input logic                 clk,
  input logic                 rst,
  id_ex_hazard_stage_if.slave bus
);
  typedef enum logic [0:0] {RUN = 1'b0, STALL = 1'b1} state_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
  } ex_t;

  // cnt counts the bubbles still owed after the current STALL cycle
  localparam logic [3:0] CNT_INIT = (STALL_CYCLES > 1) ? 4'(STALL_CYCLES - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic             hazard_s, stall_req_s, bubble_s;
  logic [CNT_W-1:0] stall_count_r;
  ex_t              ex_r, id_s;

  assign id_s = {bus.id_valid, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_reg_write,
                 bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg, bus.id_alu_src,
                 bus.id_alu_op, bus.id_rdata1, bus.id_rdata2, bus.id_imm};

  // Hazard detection, stall request and next-state / bubble selection
  always_comb begin
    hazard_s = ex_r.valid & ex_r.mem_read & (ex_r.rt != 5'd0) & bus.id_valid &
               ((ex_r.rt == bus.id_rs) | (bus.id_uses_rt & (ex_r.rt == bus.id_rt)));
    stall_req_s = (((state_r == RUN) & hazard_s) | (state_r == STALL)) & ~bus.flush;
    state_s  = state_r;
    cnt_s    = cnt_r;
    bubble_s = 1'b0;
    if (bus.flush) begin
      bubble_s = 1'b1;
      state_s  = RUN;
      cnt_s    = 4'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (hazard_s) begin
            bubble_s = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_s = STALL;
              cnt_s   = CNT_INIT;
            end else begin
              state_s = RUN;
            end
          end else begin
            bubble_s = 1'b0;
          end
        end
        STALL: begin
          bubble_s = 1'b1;
          if (cnt_r == 4'd0) begin
            state_s = RUN;
          end else begin
            cnt_s = cnt_r - 4'd1;
          end
        end
        default: begin
          state_s = RUN;
          cnt_s   = 4'd0;
        end
      endcase
    end
  end

  // Hazard FSM state and remaining-bubble counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // ID/EX pipeline register: bubble or capture every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r <= '0;
    end else if (bubble_s) begin
      ex_r <= '0;
    end else begin
      ex_r <= id_s;
    end
  end

  // Saturating count of cycles spent stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_r <= '0;
    end else if (stall_req_s && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign bus.pc_write      = ~stall_req_s;
  assign bus.if_id_write   = ~stall_req_s;
  assign bus.ex_valid      = ex_r.valid;
  assign bus.ex_rs         = ex_r.rs;
  assign bus.ex_rt         = ex_r.rt;
  assign bus.ex_rd         = ex_r.rd;
  assign bus.ex_reg_write  = ex_r.reg_write;
  assign bus.ex_mem_read   = ex_r.mem_read;
  assign bus.ex_mem_write  = ex_r.mem_write;
  assign bus.ex_mem_to_reg = ex_r.mem_to_reg;
  assign bus.ex_alu_src    = ex_r.alu_src;
  assign bus.ex_alu_op     = ex_r.alu_op;
  assign bus.ex_rdata1     = ex_r.rdata1;
  assign bus.ex_rdata2     = ex_r.rdata2;
  assign bus.ex_imm        = ex_r.imm;
  assign bus.stall_count   = stall_count_r;
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: three instances (1 bubble, 3 bubbles, 4-bit
// counter) share one input stream and are each checked against a reference model.
module tb_id_ex_hazard_stage;
  localparam int SC [3] = '{1, 3, 1};
  localparam int WC [3] = '{16, 16, 4};

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rt;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
  } ex_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic        mem_read;
    logic        flush;
    logic        pcw;
    logic        ex_valid;
    logic [4:0]  ex_rs;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  cur = '0;
  int   n_tests = 0;
  int   n_fail  = 0;

  id_ex_hazard_stage_if #(.CNT_W(WC[0])) b0 ();
  id_ex_hazard_stage_if #(.CNT_W(WC[1])) b1 ();
  id_ex_hazard_stage_if #(.CNT_W(WC[2])) b2 ();

  id_ex_hazard_stage #(.STALL_CYCLES(SC[0]), .CNT_W(WC[0])) dut0 (.clk(clk), .rst(rst), .bus(b0));
  id_ex_hazard_stage #(.STALL_CYCLES(SC[1]), .CNT_W(WC[1])) dut1 (.clk(clk), .rst(rst), .bus(b1));
  id_ex_hazard_stage #(.STALL_CYCLES(SC[2]), .CNT_W(WC[2])) dut2 (.clk(clk), .rst(rst), .bus(b2));

  always #5 clk = ~clk;

  assign {b0.id_valid, b0.id_rs, b0.id_rt, b0.id_rd, b0.id_uses_rt, b0.id_reg_write, b0.id_mem_read,
          b0.id_mem_write, b0.id_mem_to_reg, b0.id_alu_src, b0.id_alu_op, b0.id_rdata1, b0.id_rdata2,
          b0.id_imm, b0.flush} = cur;
  assign {b1.id_valid, b1.id_rs, b1.id_rt, b1.id_rd, b1.id_uses_rt, b1.id_reg_write, b1.id_mem_read,
          b1.id_mem_write, b1.id_mem_to_reg, b1.id_alu_src, b1.id_alu_op, b1.id_rdata1, b1.id_rdata2,
          b1.id_imm, b1.flush} = cur;
  assign {b2.id_valid, b2.id_rs, b2.id_rt, b2.id_rd, b2.id_uses_rt, b2.id_reg_write, b2.id_mem_read,
          b2.id_mem_write, b2.id_mem_to_reg, b2.id_alu_src, b2.id_alu_op, b2.id_rdata1, b2.id_rdata2,
          b2.id_imm, b2.flush} = cur;

  ex_t         dex [3];
  logic        pcw [3];
  logic        ifw [3];
  logic [15:0] scnt [3];

  assign dex[0] = {b0.ex_valid, b0.ex_rs, b0.ex_rt, b0.ex_rd, b0.ex_reg_write, b0.ex_mem_read, b0.ex_mem_write,
                   b0.ex_mem_to_reg, b0.ex_alu_src, b0.ex_alu_op, b0.ex_rdata1, b0.ex_rdata2, b0.ex_imm};
  assign dex[1] = {b1.ex_valid, b1.ex_rs, b1.ex_rt, b1.ex_rd, b1.ex_reg_write, b1.ex_mem_read, b1.ex_mem_write,
                   b1.ex_mem_to_reg, b1.ex_alu_src, b1.ex_alu_op, b1.ex_rdata1, b1.ex_rdata2, b1.ex_imm};
  assign dex[2] = {b2.ex_valid, b2.ex_rs, b2.ex_rt, b2.ex_rd, b2.ex_reg_write, b2.ex_mem_read, b2.ex_mem_write,
                   b2.ex_mem_to_reg, b2.ex_alu_src, b2.ex_alu_op, b2.ex_rdata1, b2.ex_rdata2, b2.ex_imm};
  assign pcw[0] = b0.pc_write;     assign pcw[1] = b1.pc_write;     assign pcw[2] = b2.pc_write;
  assign ifw[0] = b0.if_id_write;  assign ifw[1] = b1.if_id_write;  assign ifw[2] = b2.if_id_write;
  assign scnt[0] = b0.stall_count;
  assign scnt[1] = b1.stall_count;
  assign scnt[2] = {12'd0, b2.stall_count};

  // Reference model: EX contents, bubbles still owed, total stall cycles
  ex_t  mex [3];
  int   rem [3];
  int   mcnt [3];
  logic obs_pcw [3];

  function automatic ex_t capture(input in_t i);
    ex_t e;
    e = '{valid: i.valid, rs: i.rs, rt: i.rt, rd: i.rd, reg_write: i.reg_write, mem_read: i.mem_read,
          mem_write: i.mem_write, mem_to_reg: i.mem_to_reg, alu_src: i.alu_src, alu_op: i.alu_op,
          rdata1: i.rdata1, rdata2: i.rdata2, imm: i.imm};
    return e;
  endfunction

  function automatic logic m_hazard(input int d, input in_t i);
    ex_t e;
    e = mex[d];
    return e.valid && e.mem_read && (e.rt != 5'd0) && i.valid &&
           ((e.rt == i.rs) || (i.uses_rt && (e.rt == i.rt)));
  endfunction

  function automatic logic m_stall(input int d, input in_t i);
    return !i.flush && ((rem[d] > 0) || m_hazard(d, i));
  endfunction

  function automatic void m_clock(input int d, input in_t i, input logic st);
    if (st && (mcnt[d] < (1 << WC[d]) - 1)) mcnt[d]++;
    if (i.flush) begin
      mex[d] = '0; rem[d] = 0;
    end else if (rem[d] > 0) begin
      mex[d] = '0; rem[d]--;
    end else if (m_hazard(d, i)) begin
      mex[d] = '0; rem[d] = SC[d] - 1;
    end else begin
      mex[d] = capture(i);
    end
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 3; d++) begin
      mex[d] = '0; rem[d] = 0; mcnt[d] = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs in cur; returns at the next negedge
  task automatic tick();
    logic st [3];
    #1;
    for (int d = 0; d < 3; d++) begin
      st[d] = m_stall(d, cur);
      obs_pcw[d] = pcw[d];
      chk($sformatf("pc_if_write[%0d]", d), {pcw[d], ifw[d]}, {~st[d], ~st[d]});
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) m_clock(d, cur, st[d]);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("ex_regs[%0d]", d), dex[d], mex[d]);
      chk($sformatf("stall_count[%0d]", d), scnt[d], mcnt[d]);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ex[%0d]", d), dex[d], 128'd0);
      chk($sformatf("rst_cnt[%0d]", d), scnt[d], 128'd0);
      chk($sformatf("rst_pcw[%0d]", d), {pcw[d], ifw[d]}, 128'd3);
    end
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  function automatic in_t mk(input logic v, input int rs, input int rt, input logic urt,
                             input logic mr, input logic mw, input logic fl);
    in_t i;
    i = '0;
    i.valid = v; i.rs = 5'(rs); i.rt = 5'(rt); i.uses_rt = urt;
    i.mem_read = mr; i.mem_to_reg = mr; i.mem_write = mw; i.reg_write = ~mw;
    i.rd = 5'(rs + rt + 1); i.alu_op = 4'(rs); i.alu_src = mr | mw;
    i.rdata1 = $urandom(); i.rdata2 = $urandom(); i.imm = $urandom();
    i.flush = fl;
    return i;
  endfunction

  vec_t tbl [15];

  initial begin
    // valid rs rt uses_rt mem_read flush | pc_write ex_valid ex_rs stall_count (1-bubble instance)
    tbl[0]  = '{1'b1, 5'd2, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 16'd0};
    tbl[1]  = '{1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd1};
    tbl[2]  = '{1'b1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 16'd1};
    tbl[3]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 16'd1};
    tbl[4]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 16'd1};
    tbl[5]  = '{1'b1, 5'd4, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 16'd1};
    tbl[6]  = '{1'b1, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 16'd1};
    tbl[7]  = '{1'b1, 5'd6, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 16'd1};
    tbl[8]  = '{1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd2};
    tbl[9]  = '{1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 16'd2};
    tbl[10] = '{1'b1, 5'd1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 16'd2};
    tbl[11] = '{1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 16'd2};
    tbl[12] = '{1'b0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 16'd2};
    tbl[13] = '{1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 16'd2};
    tbl[14] = '{1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 16'd2};

    m_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("init_ex[%0d]", d), dex[d], 128'd0);
      chk($sformatf("init_pcw[%0d]", d), {pcw[d], ifw[d]}, 128'd3);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 15; k++) begin
      cur = mk(tbl[k].valid, int'(tbl[k].rs), int'(tbl[k].rt), tbl[k].uses_rt, tbl[k].mem_read, 1'b0, tbl[k].flush);
      tick();
      chk($sformatf("tbl%0d_pcw", k), obs_pcw[0], tbl[k].pcw);
      chk($sformatf("tbl%0d_ex_valid", k), dex[0].valid, tbl[k].ex_valid);
      chk($sformatf("tbl%0d_ex_rs", k), dex[0].rs, tbl[k].ex_rs);
      chk($sformatf("tbl%0d_cnt", k), scnt[0], tbl[k].cnt);
    end

    // Three-bubble load-use on rt (store data operand)
    do_reset();
    cur = mk(1'b1, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    cur = mk(1'b1, 2, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s3_pcw_low%0d", i), obs_pcw[1], 128'd0);
      chk($sformatf("s3_bubble%0d", i), dex[1].valid, 128'd0);
    end
    tick();
    chk("s3_release_pcw", obs_pcw[1], 128'd1);
    chk("s3_release_ex", {dex[1].valid, dex[1].rt, dex[1].mem_write}, {1'b1, 5'd1, 1'b1});
    chk("s3_count", scnt[1], 128'd3);

    // Flush in the second stall cycle ends the stall
    do_reset();
    cur = mk(1'b1, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    cur = mk(1'b1, 1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    cur.flush = 1'b1;
    tick();
    chk("flush_stall_pcw", obs_pcw[1], 128'd1);
    chk("flush_stall_bubble", dex[1].valid, 128'd0);
    cur = mk(1'b1, 7, 8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("flush_next_pcw", obs_pcw[1], 128'd1);
    chk("flush_next_ex", {dex[1].valid, dex[1].rs}, {1'b1, 5'd7});
    chk("flush_count", scnt[1], 128'd1);

    // Reset in the middle of a three-cycle stall abandons it
    cur = mk(1'b1, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    cur = mk(1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();
    tick();
    chk("rst_abandon_pcw", obs_pcw[1], 128'd1);
    chk("rst_abandon_ex", {dex[1].valid, dex[1].rs}, {1'b1, 5'd2});

    // 20 single-cycle stalls: 4-bit counter saturates at 15
    do_reset();
    cur = mk(1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      tick();
      if (i == 14) chk("sat_at15", scnt[2], 128'd15);
    end
    chk("sat_hold", scnt[2], 128'd15);
    chk("sat_wide", scnt[0], 128'd20);

    // Randomized traffic biased toward low register numbers
    for (int k = 0; k < 400; k++) begin
      cur = mk($urandom_range(7, 0) != 0, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               $urandom_range(7, 0) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection and stall/flush control for the 5-stage MIPS pipeline. Registers decoded operands and control from ID and presents ex_rs/ex_rt/ex_rd/ex_reg_write to the EX stage and the forwarding unit. Detects a load in EX whose destination matches a source register in ID, then inserts bubbles and freezes PC and IF/ID for STALL_CYCLES cycles. A branch-taken flush squashes the ID instruction.

Parameters:
STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15; 1 = classic MIPS with full forwarding)
CNT_W, 16, width of saturating stall statistics counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
id_rd  in  5  ID destination (already muxed by RegDst)
id_uses_rt  in  1  instruction reads rt as a source (R-type, sw, beq)
id_reg_write  in  1  control: RegWrite
id_mem_read  in  1  control: MemRead
id_mem_write  in  1  control: MemWrite
id_mem_to_reg  in  1  control: MemtoReg
id_alu_src  in  1  control: ALUSrc
id_alu_op  in  4  ALU operation
id_rdata1  in  32  register file read port 1
id_rdata2  in  32  register file read port 2
id_imm  in  32  sign-extended immediate
flush  in  1  branch taken; squash the instruction in ID
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
ex_valid  out  1  EX holds a real instruction
ex_rs, ex_rt, ex_rd  out  5 each  registered register numbers
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1 each  registered control
ex_alu_op  out  4  registered ALU op
ex_rdata1, ex_rdata2, ex_imm  out  32 each  registered data
stall_count  out  CNT_W  total stall cycles since reset

Behaviour:
- Reset (asynchronous, immediate): all ex_* = 0 (a bubble), state = RUN, cnt = 0, stall_count = 0. pc_write = if_id_write = 1 while in reset. Reset mid-stall abandons the stall.
- hazard (combinational) = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- stall_req = ((state==RUN & hazard) | state==STALL) & !flush. pc_write = if_id_write = !stall_req (combinational, same cycle).
- Bubble: ex_valid = 0, all ex control bits = 0, register numbers/data = 0.
- Each posedge, priority order:
  1. flush: load bubble; state -> RUN; cnt -> 0.
  2. state==RUN & hazard: load bubble; if STALL_CYCLES>1, state -> STALL, cnt = STALL_CYCLES-2; otherwise stay in RUN.
  3. state==STALL: load bubble; if cnt==0, state -> RUN; else cnt decrements.
  4. otherwise: capture all id_* into ex_*; ex_valid = id_valid.
- Hazard is evaluated only in RUN. After the bubbles, the load has left EX, so the held ID instruction proceeds and its operand comes from forwarding.
- stall_count increments on each clock where stall_req = 1. It saturates at all-ones and does not wrap.
- Register 0 never causes a hazard. A store (id_mem_write) reading rt as data counts as id_uses_rt.
- Latency: one cycle from ID inputs to ex_* outputs when not stalled.

Test Plan:
- Reset asserted mid-operation (async, between edges) -> ex_* = 0 and stall_count = 0 immediately; pc_write = 1.
- lw $1 in EX (ex_mem_read=1, ex_rt=1); ID add rs=1 -> pc_write = if_id_write = 0 that cycle; next edge ex_valid = 0. Following cycle pc_write = 1, add is captured with ex_rs = 1; stall_count = 1.
- lw ex_rt=0 with ID rs=0, or lw ex_rt=2 with ID rt=2 and id_uses_rt=0 -> no stall; ID is captured next edge.
- STALL_CYCLES=3, load-use on rt (id_uses_rt=1) -> exactly 3 consecutive bubbles with pc_write low for 3 cycles; stall_count = 3.
- Hazard and flush in the same cycle -> pc_write = 1, bubble loaded, state RUN, stall_count unchanged. Flush during STALL (STALL_CYCLES=3, 2nd cycle) -> stall ends, next cycle captures new ID.
- CNT_W=4, 20 stall cycles -> stall_count = 15 and holds there.
